// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, step encoding and control-word helpers for eater_core
package cpu_pkg;

    // Control word bit positions
    localparam int unsigned CW_HLT = 15;
    localparam int unsigned CW_MI  = 14;
    localparam int unsigned CW_RI  = 13;
    localparam int unsigned CW_RO  = 12;
    localparam int unsigned CW_IO  = 11;
    localparam int unsigned CW_II  = 10;
    localparam int unsigned CW_AI  = 9;
    localparam int unsigned CW_AO  = 8;
    localparam int unsigned CW_EO  = 7;
    localparam int unsigned CW_SU  = 6;
    localparam int unsigned CW_BI  = 5;
    localparam int unsigned CW_OI  = 4;
    localparam int unsigned CW_CE  = 3;
    localparam int unsigned CW_CO  = 2;
    localparam int unsigned CW_J   = 1;
    localparam int unsigned CW_FI  = 0;

    // Flag positions
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 0;

    // Opcodes (IR[7:4])
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Microcode step counter: five steps, T0..T4
    localparam int unsigned STEP_COUNT = 5;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam step_t LAST_STEP = step_t'(STEP_COUNT - 1);

    function automatic logic [15:0] cw_mask(input int unsigned idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/core_microcode.sv
// rtl/core_microcode.sv - combinational microcode decoder (opcode, step, flags, halted) -> control word
//
// Ports:
//   i_opcode       IR[7:4]
//   i_step         current microcode step
//   i_flags        latched {carry, zero}
//   i_halted       core halted; forces the HLT-only word
//   o_control_word 16-bit control word
module core_microcode
    import cpu_pkg::*;
(
    input  logic [3:0]  i_opcode,
    input  step_t       i_step,
    input  logic [1:0]  i_flags,
    input  logic        i_halted,
    output logic [15:0] o_control_word
);

    always_comb begin
        o_control_word = '0;
        if (i_halted) begin
            o_control_word = cw_mask(CW_HLT);
        end else begin
            case (i_step)
                T0: o_control_word = cw_mask(CW_CO) | cw_mask(CW_MI);
                T1: o_control_word = cw_mask(CW_RO) | cw_mask(CW_II) | cw_mask(CW_CE);
                T2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA:
                            o_control_word = cw_mask(CW_IO) | cw_mask(CW_MI);
                        OP_LDI: o_control_word = cw_mask(CW_IO) | cw_mask(CW_AI);
                        OP_JMP: o_control_word = cw_mask(CW_IO) | cw_mask(CW_J);
                        OP_JC: begin
                            if (i_flags[FLAG_C]) o_control_word = cw_mask(CW_IO) | cw_mask(CW_J);
                        end
                        OP_JZ: begin
                            if (i_flags[FLAG_Z]) o_control_word = cw_mask(CW_IO) | cw_mask(CW_J);
                        end
                        OP_OUT: o_control_word = cw_mask(CW_AO) | cw_mask(CW_OI);
                        OP_HLT: o_control_word = cw_mask(CW_HLT);
                        OP_NOP: o_control_word = '0;
                        default: o_control_word = '0;
                    endcase
                end
                T3: begin
                    case (i_opcode)
                        OP_LDA:         o_control_word = cw_mask(CW_RO) | cw_mask(CW_AI);
                        OP_ADD, OP_SUB: o_control_word = cw_mask(CW_RO) | cw_mask(CW_BI);
                        OP_STA:         o_control_word = cw_mask(CW_AO) | cw_mask(CW_RI);
                        default:        o_control_word = '0;
                    endcase
                end
                T4: begin
                    case (i_opcode)
                        OP_ADD: o_control_word = cw_mask(CW_EO) | cw_mask(CW_AI) | cw_mask(CW_FI);
                        OP_SUB: o_control_word = cw_mask(CW_EO) | cw_mask(CW_SU)
                                               | cw_mask(CW_AI) | cw_mask(CW_FI);
                        default: o_control_word = '0;
                    endcase
                end
                default: o_control_word = '0;
            endcase
        end
    end

endmodule

// File: rtl/eater_core.sv
// rtl/eater_core.sv - SAP-1 style core: PC, MAR, IR, RAM, ALU, flags and microcode sequencer
//
// Ports:
//   clk           clock, rising edge
//   clear         asynchronous active-high reset (RAM contents kept)
//   a_in, b_in    external A/B register values (ALU operands)
//   bus_in        resolved shared bus
//   bus_out       value driven onto the bus by CO/RO/IO/EO
//   bus_oe        1 while one of those sources is active
//   control_word  decoded control signals for the whole machine
//   flags         {carry, zero}
//   halted        set by HLT, cleared only by clear
module eater_core
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4
)
(
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [7:0]  bus_in,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    output logic [15:0] control_word,
    output logic [1:0]  flags,
    output logic        halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Name kept as `ram` so simulations can preload it hierarchically
    logic [7:0]        ram [0:DEPTH-1];

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [7:0]        r_ir;
    logic [1:0]        r_flags;
    logic              r_halted;
    step_t             r_step;
    step_t             w_step_next;

    logic [15:0]       w_cw;
    logic [8:0]        w_alu;
    logic [7:0]        w_sum;
    logic              w_su;

    core_microcode u_microcode (
        .i_opcode       (r_ir[7:4]),
        .i_step         (r_step),
        .i_flags        (r_flags),
        .i_halted       (r_halted),
        .o_control_word (w_cw)
    );

    // Subtract is two's complement: invert B and feed SU in as carry-in
    assign w_su  = w_cw[CW_SU];
    assign w_alu = {1'b0, a_in} + {1'b0, (w_su ? ~b_in : b_in)} + {8'h00, w_su};
    assign w_sum = w_alu[7:0];

    // Bus source mux; priority only matters if the microcode ever overlaps sources
    always_comb begin
        bus_out = 8'h00;
        bus_oe  = 1'b0;
        if (w_cw[CW_EO]) begin
            bus_out = w_sum;
            bus_oe  = 1'b1;
        end else if (w_cw[CW_RO]) begin
            bus_out = ram[r_mar];
            bus_oe  = 1'b1;
        end else if (w_cw[CW_IO]) begin
            bus_out = {4'h0, r_ir[3:0]};
            bus_oe  = 1'b1;
        end else if (w_cw[CW_CO]) begin
            bus_out = 8'(r_pc);
            bus_oe  = 1'b1;
        end
    end

    // Step sequencer; holds on the HLT step and while halted
    always_comb begin
        w_step_next = r_step;
        if (!r_halted && !w_cw[CW_HLT]) begin
            w_step_next = (r_step == LAST_STEP) ? T0 : step_t'(r_step + 3'd1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_step   <= T0;
            r_pc     <= '0;
            r_mar    <= '0;
            r_ir     <= '0;
            r_flags  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_step <= w_step_next;
            if (w_cw[CW_HLT]) r_halted <= 1'b1;
            if (w_cw[CW_MI])  r_mar    <= bus_in[ADDR_W-1:0];
            if (w_cw[CW_II])  r_ir     <= bus_in;
            if (w_cw[CW_J]) begin
                r_pc <= bus_in[ADDR_W-1:0];
            end else if (w_cw[CW_CE]) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_cw[CW_FI]) begin
                r_flags[FLAG_C] <= w_alu[8];
                r_flags[FLAG_Z] <= (w_sum == 8'h00);
            end
        end
    end

    // RAM is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (w_cw[CW_RI]) ram[r_mar] <= bus_in;
    end

    assign control_word = w_cw;
    assign flags        = r_flags;
    assign halted       = r_halted;

endmodule

// File: tb/tb_eater_core.sv
// tb/tb_eater_core.sv - self-checking bench for eater_core with an instruction-level reference model
module tb_eater_core;
    import cpu_pkg::*;

    logic        clk   = 1'b0;
    logic        clear = 1'b1;
    logic [7:0]  a_reg = 8'h00;
    logic [7:0]  b_reg = 8'h00;
    logic [7:0]  out_reg = 8'h00;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [15:0] cw;
    logic [1:0]  flags;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    // Instruction-level reference machine
    logic [7:0] m_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_a, m_b, m_out;
    logic       m_c, m_z, m_halt;

    eater_core #(.ADDR_W(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .a_in         (a_reg),
        .b_in         (b_reg),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .control_word (cw),
        .flags        (flags),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // External bus: core sources, else A when AO
    assign bus_in = bus_oe ? bus_out : (cw[CW_AO] ? a_reg : 8'h00);

    // External A, B and output registers
    always @(posedge clk) begin
        if (clear) begin
            a_reg   <= 8'h00;
            b_reg   <= 8'h00;
            out_reg <= 8'h00;
        end else begin
            if (cw[CW_AI]) a_reg   <= bus_in;
            if (cw[CW_BI]) b_reg   <= bus_in;
            if (cw[CW_OI]) out_reg <= bus_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    // Load m_mem into the DUT, reset both machines, leave at T0 on a falling edge
    task automatic start();
        @(negedge clk);
        clear = 1'b1;
        for (int i = 0; i < 16; i++) dut.ram[i] = m_mem[i];
        m_pc = 4'h0; m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic model_exec();
        logic [7:0] ins;
        logic [3:0] x;
        int         s;
        if (m_halt) return;
        ins  = m_mem[m_pc];
        x    = ins[3:0];
        m_pc = m_pc + 4'd1;
        case (ins[7:4])
            4'h1: m_a = m_mem[x];
            4'h2: begin
                m_b = m_mem[x];
                s   = int'(m_a) + int'(m_b);
                m_c = (s > 255);
                m_a = 8'(s);
                m_z = (m_a == 8'h00);
            end
            4'h3: begin
                m_b = m_mem[x];
                m_c = (m_a >= m_b);       // no borrow
                m_a = m_a - m_b;
                m_z = (m_a == 8'h00);
            end
            4'h4: m_mem[x] = m_a;
            4'h5: m_a = {4'h0, x};
            4'h6: m_pc = x;
            4'h7: if (m_c) m_pc = x;
            4'h8: if (m_z) m_pc = x;
            4'hE: m_out = m_a;
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_instr();
        repeat (5) tick();
        model_exec();
    endtask

    task automatic test_reset();
        clear_mem();
        m_mem[0] = 8'h1E;
        start();
        n_total++; if (cw !== 16'h4004) $display("FAIL reset_t0_cw got=%h exp=4004", cw); else n_pass++;
        n_total++; if (dut.r_pc !== 4'h0) $display("FAIL reset_pc got=%h exp=0", dut.r_pc); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL reset_flags got=%b exp=00", flags); else n_pass++;
        tick();
        n_total++; if (cw !== 16'h1408) $display("FAIL fetch_t1_cw got=%h exp=1408", cw); else n_pass++;
        tick();
        n_total++; if (dut.r_ir !== 8'h1E) $display("FAIL fetch_ir got=%h exp=1e", dut.r_ir); else n_pass++;
        n_total++; if (dut.r_pc !== 4'h1) $display("FAIL fetch_pc got=%h exp=1", dut.r_pc); else n_pass++;
    endtask

    task automatic test_lda_add();
        clear_mem();
        m_mem[0] = 8'h1E; m_mem[1] = 8'h2F; m_mem[14] = 8'd28; m_mem[15] = 8'd14;
        start();
        run_instr();
        run_instr();
        n_total++; if (a_reg !== 8'd42) $display("FAIL add_a got=%0d exp=42", a_reg); else n_pass++;
        n_total++; if (flags !== 2'b00) $display("FAIL add_flags got=%b exp=00", flags); else n_pass++;
        n_total++; if (a_reg !== m_a) $display("FAIL add_model_a got=%h exp=%h", a_reg, m_a); else n_pass++;
    endtask

    task automatic test_sub();
        clear_mem();
        m_mem[0] = 8'h55; m_mem[1] = 8'h3F; m_mem[2] = 8'h53; m_mem[3] = 8'h3F; m_mem[15] = 8'h05;
        start();
        run_instr();
        run_instr();
        n_total++; if (a_reg !== 8'h00) $display("FAIL sub_eq_a got=%h exp=00", a_reg); else n_pass++;
        n_total++; if (flags !== 2'b11) $display("FAIL sub_eq_flags got=%b exp=11", flags); else n_pass++;
        run_instr();
        repeat (4) tick();
        n_total++; if (bus_out !== 8'hFE || bus_oe !== 1'b1)
            $display("FAIL sub_sum_bus got=%h/%b exp=fe/1", bus_out, bus_oe); else n_pass++;
        tick();
        model_exec();
        n_total++; if (flags !== 2'b00) $display("FAIL sub_lt_flags got=%b exp=00", flags); else n_pass++;
        n_total++; if (a_reg !== 8'hFE) $display("FAIL sub_lt_a got=%h exp=fe", a_reg); else n_pass++;
    endtask

    task automatic test_jumps();
        logic [7:0] ops [2];
        ops[0] = 8'h7A;
        ops[1] = 8'h8A;
        for (int k = 0; k < 2; k++) begin
            // Flags clear: conditional jump falls through
            clear_mem();
            m_mem[0] = ops[k];
            start();
            run_instr();
            n_total++; if (dut.r_pc !== 4'h1) $display("FAIL jump_not_taken op=%h got=%h exp=1", ops[k], dut.r_pc); else n_pass++;
            // 5-5 sets both carry and zero, so the jump is taken
            clear_mem();
            m_mem[0] = 8'h55; m_mem[1] = 8'h3F; m_mem[2] = ops[k]; m_mem[15] = 8'h05;
            start();
            run_instr();
            run_instr();
            repeat (3) tick();
            n_total++; if (dut.r_pc !== 4'hA) $display("FAIL jump_taken op=%h got=%h exp=a", ops[k], dut.r_pc); else n_pass++;
        end
    endtask

    task automatic test_sta_ldi();
        clear_mem();
        m_mem[0] = 8'h1C; m_mem[1] = 8'h4D; m_mem[2] = 8'h59; m_mem[12] = 8'h5A;
        start();
        run_instr();
        run_instr();
        n_total++; if (dut.ram[13] !== 8'h5A) $display("FAIL sta_ram got=%h exp=5a", dut.ram[13]); else n_pass++;
        repeat (2) tick();
        n_total++; if (bus_out !== 8'h09 || bus_oe !== 1'b1)
            $display("FAIL ldi_bus got=%h/%b exp=09/1", bus_out, bus_oe); else n_pass++;
        n_total++; if (cw !== 16'h0A00) $display("FAIL ldi_cw got=%h exp=0a00", cw); else n_pass++;
        tick();
        n_total++; if (bus_out !== 8'h00 || bus_oe !== 1'b0)
            $display("FAIL idle_bus got=%h/%b exp=00/0", bus_out, bus_oe); else n_pass++;
        n_total++; if (a_reg !== 8'h09) $display("FAIL ldi_a got=%h exp=09", a_reg); else n_pass++;
    endtask

    task automatic test_halt();
        clear_mem();
        m_mem[0] = 8'h51; m_mem[1] = 8'h52; m_mem[2] = 8'h53; m_mem[3] = 8'hF0;
        start();
        repeat (4) run_instr();
        n_total++; if (halted !== 1'b1) $display("FAIL halt_set got=%b exp=1", halted); else n_pass++;
        n_total++; if (a_reg !== 8'h03) $display("FAIL halt_a got=%h exp=03", a_reg); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            n_total++; if (cw !== 16'h8000) $display("FAIL halt_cw cyc=%0d got=%h exp=8000", c, cw); else n_pass++;
            n_total++; if (dut.r_pc !== 4'h4) $display("FAIL halt_pc cyc=%0d got=%h exp=4", c, dut.r_pc); else n_pass++;
            tick();
        end
        clear = 1'b1;
        #1;
        n_total++; if (dut.r_pc !== 4'h0 || halted !== 1'b0)
            $display("FAIL halt_clear got=%h/%b exp=0/0", dut.r_pc, halted); else n_pass++;
        tick();
        clear = 1'b0;
        n_total++; if (cw !== 16'h4004) $display("FAIL halt_restart_cw got=%h exp=4004", cw); else n_pass++;
    endtask

    task automatic test_clear_mid();
        clear_mem();
        m_mem[0] = 8'h57; m_mem[1] = 8'h1E; m_mem[14] = 8'hAB;
        start();
        run_instr();
        repeat (3) tick();
        clear = 1'b1;
        #1;
        n_total++; if (dut.r_pc !== 4'h0) $display("FAIL abort_pc got=%h exp=0", dut.r_pc); else n_pass++;
        tick();
        clear = 1'b0;
        run_instr();
        n_total++; if (dut.r_ir !== 8'h57 || a_reg !== 8'h07)
            $display("FAIL abort_refetch got=%h/%h exp=57/07", dut.r_ir, a_reg); else n_pass++;
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'($urandom);
            start();
            for (int n = 0; n < 25; n++) begin
                run_instr();
                n_total++; if (dut.r_pc !== m_pc) $display("FAIL rnd_pc p=%0d n=%0d got=%h exp=%h", p, n, dut.r_pc, m_pc); else n_pass++;
                n_total++; if (a_reg !== m_a) $display("FAIL rnd_a p=%0d n=%0d got=%h exp=%h", p, n, a_reg, m_a); else n_pass++;
                n_total++; if (b_reg !== m_b) $display("FAIL rnd_b p=%0d n=%0d got=%h exp=%h", p, n, b_reg, m_b); else n_pass++;
                n_total++; if (flags !== {m_c, m_z}) $display("FAIL rnd_flags p=%0d n=%0d got=%b exp=%b", p, n, flags, {m_c, m_z}); else n_pass++;
                n_total++; if (halted !== m_halt) $display("FAIL rnd_halted p=%0d n=%0d got=%b exp=%b", p, n, halted, m_halt); else n_pass++;
                n_total++; if (out_reg !== m_out) $display("FAIL rnd_out p=%0d n=%0d got=%h exp=%h", p, n, out_reg, m_out); else n_pass++;
            end
            for (int i = 0; i < 16; i++) begin
                n_total++; if (dut.ram[i] !== m_mem[i]) $display("FAIL rnd_ram p=%0d addr=%0d got=%h exp=%h", p, i, dut.ram[i], m_mem[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda_add();
        test_sub();
        test_jumps();
        test_sta_ldi();
        test_halt();
        test_clear_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
